// File: rtl/br_pred_pipe.sv
// Next-PC / prediction-tracking stage: owns PC_IF, carries BTB predictions to EX, resolves and redirects.
// Optional statistics counters are built when BR_PRED_STAT_EN is defined; otherwise br_cnt/fail_cnt read 0.
module br_pred_pipe #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             find,
  input  logic             jmp,
  input  logic [31:0]      NPC_Pred,
  input  logic             is_br_EX,
  input  logic             br_EX,
  input  logic [31:0]      br_target,
  output logic [31:0]      PC_IF,
  output logic [31:0]      PC_EX,
  output logic             find_EX,
  output logic             jmp_EX,
  output logic [31:0]      NPC_Pred_EX,
  output logic             fail,
  output logic             flush,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic        find;
    logic        jmp;
    logic [31:0] npc;
  } slot_t;

  localparam slot_t BUBBLE = '0;

  logic [31:0] pc_q;
  slot_t       id_q, ex_q;

  assign PC_IF       = pc_q;
  assign PC_EX       = ex_q.pc;
  assign find_EX     = ex_q.find;
  assign jmp_EX      = ex_q.jmp;
  assign NPC_Pred_EX = ex_q.npc;

  // Wrong direction, or taken-as-predicted but to a different target.
  assign fail  = ex_q.vld & ((ex_q.jmp != br_EX) |
                             (ex_q.jmp & br_EX & (ex_q.npc != br_target)));
  assign flush = fail;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      id_q <= BUBBLE;
      ex_q <= BUBBLE;
    end else if (fail) begin
      pc_q <= br_EX ? br_target : ex_q.pc + 32'd4;
      id_q <= BUBBLE;
      ex_q <= BUBBLE;
    end else if (stall) begin
      ex_q <= BUBBLE;
    end else begin
      pc_q <= NPC_Pred;
      id_q <= '{vld: 1'b1, pc: pc_q, find: find, jmp: jmp, npc: NPC_Pred};
      ex_q <= id_q;
    end
  end

`ifdef BR_PRED_STAT_EN
  logic [CNT_W-1:0] br_q, fail_q;

  // Both counters stick at all-ones until the next reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      br_q   <= '0;
      fail_q <= '0;
    end else begin
      if (ex_q.vld & is_br_EX & ~&br_q) br_q   <= br_q + CNT_W'(1);
      if (fail & ~&fail_q)              fail_q <= fail_q + CNT_W'(1);
    end
  end

  assign br_cnt   = br_q;
  assign fail_cnt = fail_q;
`else
  logic unused_is_br;
  assign unused_is_br = is_br_EX;
  assign br_cnt       = '0;
  assign fail_cnt     = '0;
`endif

endmodule

// File: doc/br_pred_pipe.md
Name: br_pred_pipe

Overview:
- Next-PC and prediction-tracking stage upstream of the branch target buffer.
- Owns the IF program counter and consumes the buffer's IF-stage prediction (find, jmp, NPC_Pred).
- Carries that prediction through IF/ID and ID/EX, hands it back to the buffer at EX, resolves mispredictions and redirects the PC.
- Also drives pipeline flush strobes and branch statistics counters.

Parameters:
- RESET_PC, 32'h0000_0000, PC_IF value after reset.
- CNT_W, 32, width of the statistics counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- stall  in  1  load-use hazard: freeze PC_IF and the IF/ID slot, insert bubble into ID/EX.
- find  in  1  buffer hit for current PC_IF.
- jmp  in  1  buffer predicts taken for current PC_IF.
- NPC_Pred  in  32  predicted next PC for current PC_IF.
- is_br_EX  in  1  EX instruction is a branch (0 for bubbles).
- br_EX  in  1  EX branch actually taken.
- br_target  in  32  EX resolved target.
- PC_IF  out  32  fetch address.
- PC_EX  out  32  PC of EX slot.
- find_EX  out  1  hit flag carried to EX.
- jmp_EX  out  1  predicted-taken flag carried to EX.
- NPC_Pred_EX  out  32  predicted next PC carried to EX.
- fail  out  1  EX misprediction, combinational.
- flush  out  1  equals fail; the datapath clears its IF/ID and ID/EX slots with it.
- br_cnt  out  CNT_W  resolved branches.
- fail_cnt  out  CNT_W  mispredictions.

Behaviour:
- All state updates on posedge clk. rst is synchronous and has top priority.
- Reset values:
  - PC_IF = RESET_PC.
  - IF/ID and ID/EX slots: valid=0, PC=0, find=0, jmp=0, npc=0.
  - br_cnt = 0, fail_cnt = 0.
  - Consequences: fail=0, flush=0, PC_EX=0, find_EX=0, jmp_EX=0, NPC_Pred_EX=0.
- Internal slots:
  - IF/ID holds {valid_ID, PC_ID, find_ID, jmp_ID, npc_ID}.
  - ID/EX holds {valid_EX, PC_EX, find_EX, jmp_EX, NPC_Pred_EX}.
- fail = valid_EX & ( (jmp_EX != br_EX) | (jmp_EX & br_EX & (NPC_Pred_EX != br_target)) ).
  - A non-branch with jmp_EX=1 fails, since br_EX=0.
- Per-cycle priority (not reset): fail > stall > advance.
- fail=1:
  - PC_IF <= br_EX ? br_target : PC_EX + 4 (32-bit wrap).
  - Both slots cleared to bubble (valid=0, find=0, jmp=0; PC and npc zeroed).
  - stall is ignored that cycle.
- stall=1, fail=0:
  - PC_IF and IF/ID hold.
  - ID/EX loads a bubble.
- Advance:
  - PC_IF <= NPC_Pred.
  - IF/ID <= {1, PC_IF, find, jmp, NPC_Pred}.
  - ID/EX <= IF/ID.
- Redirect latency: fail in cycle N, so the corrected PC_IF is visible in cycle N+1, and the first valid EX after it arrives at N+3.
- PC_IF + 4 and PC_EX + 4 wrap modulo 2^32. No alignment check: the low 2 bits pass through.
- Counters:
  - br_cnt increments when valid_EX & is_br_EX.
  - fail_cnt increments when fail.
  - Both saturate at all-ones and are reset only by rst.
- rst mid-flush or mid-stall discards everything; the next cycle fetches RESET_PC with empty slots.

Optional Feature:
- BR_PRED_STAT_EN defined: br_cnt and fail_cnt are implemented as above.
- Undefined: no counter flops; br_cnt and fail_cnt are tied to 0. All other behaviour is identical.

Test Plan:
1. Reset and sequential fetch:
   - Stimulus: rst high 2 cycles, then low with find=0, jmp=0, NPC_Pred=PC_IF+4.
   - Required: PC_IF = 0, 4, 8, 12; PC_EX = 0 two cycles after PC_IF = 0; fail stays 0.
2. Correct taken prediction:
   - Stimulus: at PC_IF=0x10 drive find=1, jmp=1, NPC_Pred=0x40; at EX drive is_br_EX=1, br_EX=1, br_target=0x40.
   - Required: fail=0, PC_EX=0x10, NPC_Pred_EX=0x40, br_cnt +1.
3. Taken-not-predicted:
   - Stimulus: 0x20 fetched with find=0; at EX br_EX=1, br_target=0x80.
   - Required: fail=1 one cycle; next PC_IF=0x80; the following two EX cycles have valid_EX=0 (find_EX=0, jmp_EX=0); fail_cnt=1.
4. Predicted-taken on non-branch and wrong target:
   - Stimulus A: jmp_EX=1, is_br_EX=0, PC_EX=0x30.
   - Required A: fail=1, PC_IF <= 0x34.
   - Stimulus B: jmp_EX=1, br_EX=1, NPC_Pred_EX=0x50, br_target=0x60.
   - Required B: fail=1, PC_IF <= 0x60.
5. Stall and stall+fail:
   - Stimulus: stall=1 for 2 cycles at PC_IF=0x8.
   - Required: PC_IF holds 0x8, two EX bubbles, then resume at 0xC.
   - Stimulus: stall=1 while fail=1.
   - Required: redirect wins, PC_IF = br_target.
6. Wrap and saturation:
   - Stimulus: PC_EX=0xFFFF_FFFC mispredicted not-taken.
   - Required: PC_IF <= 0x0000_0000.
   - Stimulus: with CNT_W=4, 20 failures.
   - Required: fail_cnt=15.
   - Stimulus: BR_PRED_STAT_EN undefined.
   - Required: br_cnt = fail_cnt = 0 throughout.
